// File: rtl/sram_pkg.sv
// Shared defaults and FSM state type for the single-port SRAM responder.
package sram_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 12;
  localparam int RD_LAT_DEF = 1;

  // Wide enough to count down from RD_LAT-1 for RD_LAT up to 4
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/sram_array.sv
// Single-port storage: synchronous write, registered read, contents never reset.
module sram_array #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Request/ack front end for sram_array: one transaction at a time, no queuing.
// Optional SRAM_PARITY_EN stores an even-parity bit per word and flags it on reads.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_we,
  input  logic              i_sel_we,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_par_flip,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_par_err
);

`ifdef SRAM_PARITY_EN
  localparam int MWIDTH = DWIDTH + 1;
`else
  localparam int MWIDTH = DWIDTH;
`endif

  // Handshake: a request is taken on any edge with i_ce=1 while IDLE; inputs are
  // ignored while o_busy=1, and o_ack pulses for one cycle when the access is done.
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                we_q;
  logic [AWIDTH-1:0]   mem_addr;
  logic [MWIDTH-1:0]   mem_wdata;
  logic [MWIDTH-1:0]   mem_rdata;
  logic                mem_we;

  // In IDLE the array already looks up the incoming address so a 1-cycle read works.
  assign mem_addr = (state == IDLE) ? i_addr : addr_q;
  // Gated by reset so an abort on the would-be write edge leaves the array untouched.
  assign mem_we   = (state == ACCESS) && we_q && i_rst_n;

`ifdef SRAM_PARITY_EN
  logic flip_q;
  assign mem_wdata = {(^wdata_q) ^ flip_q, wdata_q};
`else
  logic unused_par_flip;
  assign unused_par_flip = i_par_flip;
  assign mem_wdata = wdata_q;
`endif

  sram_array #(
    .WIDTH  (MWIDTH),
    .AWIDTH (AWIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      o_ack     <= 1'b0;
      o_busy    <= 1'b0;
      o_rdata   <= '0;
      o_par_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_ack <= 1'b0;
          if (i_ce) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            we_q    <= i_we & i_sel_we;
`ifdef SRAM_PARITY_EN
            flip_q  <= i_par_flip;
`endif
            cnt     <= (i_we & i_sel_we) ? '0 : CNT_W'(RD_LAT - 1);
            state   <= ACCESS;
            o_busy  <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= ACK;
            o_ack <= 1'b1;
            if (!we_q) begin
              o_rdata <= mem_rdata[DWIDTH-1:0];
`ifdef SRAM_PARITY_EN
              o_par_err <= ^mem_rdata;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          state  <= IDLE;
          o_ack  <= 1'b0;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_ack  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_sram_responder;

  localparam int DW     = 16;
  localparam int AW     = 12;
  localparam int RD_LAT = 3;
`ifdef SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          we = 1'b0;
  logic          sel_we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          par_flip = 1'b0;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;
  logic          par_err;

  int n_cmp = 0;
  int n_bad = 0;

  sram_responder #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_ce       (ce),
    .i_we       (we),
    .i_sel_we   (sel_we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_par_flip (par_flip),
    .o_rdata    (rdata),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_par_err  (par_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request taken at edge 0 occupies edges 0..lat,
  // acks after edge lat-1, writes the word after edge 1, and reads data after edge lat-1.
  logic [DW-1:0] mem_m [2**AW];
  bit            bad_m [2**AW];
  bit            m_active = 0;
  int            m_k = 0;
  int            m_lat = 0;
  bit            m_we = 0;
  bit            m_f = 0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;
  logic          exp_ack = 0;
  logic          exp_busy = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_perr = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active  = 0;
      exp_ack   = 0;
      exp_busy  = 0;
      exp_rdata = '0;
      exp_perr  = 0;
    end else begin
      exp_ack = 0;
      if (m_active) begin
        m_k++;
        if (m_we && m_k == 1) begin
          mem_m[m_a] = m_d;
          bad_m[m_a] = m_f;
        end
        if (!m_we && m_k == m_lat - 1) begin
          exp_rdata = mem_m[m_a];
          exp_perr  = PAR & bad_m[m_a];
        end
        exp_ack = (m_k == m_lat - 1);
        if (m_k == m_lat) m_active = 0;
      end else if (ce) begin
        m_active = 1;
        m_k      = 0;
        m_we     = we & sel_we;
        m_a      = addr;
        m_d      = wdata;
        m_f      = par_flip;
        m_lat    = m_we ? 2 : RD_LAT + 1;
      end
      exp_busy = m_active;
    end
  end

  // Scoreboard compare: every cycle once reset has been seen by the model
  bit chk_en = 0;
  bit prev_ack = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", ack, exp_ack);
      chk("busy", busy, exp_busy);
      chk("rdata", rdata, exp_rdata);
      chk("par_err", par_err, exp_perr);
      if (prev_ack && ack) chk("ack_adjacent", 1, 0);
      prev_ack = ack;
    end
  end

  // Driver: called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic txn(input bit t_we, input bit t_sel, input logic [AW-1:0] t_a,
                     input logic [DW-1:0] t_d, input bit t_f,
                     output int lat, output logic [DW-1:0] rd, output logic perr);
    ce = 1; we = t_we; sel_we = t_sel; addr = t_a; wdata = t_d; par_flip = t_f;
    @(posedge clk);
    @(negedge clk);
    ce = 0; we = 0; sel_we = 0; par_flip = 0;
    lat = 0;
    rd = 'x;
    perr = 1'bx;
    for (int j = 1; j <= 12; j++) begin
      if (ack) begin
        lat = j; rd = rdata; perr = par_err;
        break;
      end
      @(negedge clk);
    end
    chk("ack_seen", (lat != 0), 1);
    @(negedge clk);
  endtask

  int            lat;
  logic [DW-1:0] rd;
  logic          perr;
  int            acks;

  initial begin
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_par_err", par_err, 0);
    rst_n = 1;
    @(negedge clk);

    // write then read back
    txn(1, 1, 12'h07F, 16'hA5C3, 0, lat, rd, perr);
    chk("wr_latency", lat, 2);
    chk("wr_keeps_rdata", rd, 16'h0000);
    txn(0, 0, 12'h07F, 16'h0000, 0, lat, rd, perr);
    chk("rd_latency", lat, RD_LAT + 1);
    chk("rd_data", rd, 16'hA5C3);

    // write without qualifier behaves as a read and leaves the word alone
    txn(1, 0, 12'h07F, 16'hFFFF, 0, lat, rd, perr);
    chk("unqual_latency", lat, RD_LAT + 1);
    chk("unqual_data", rd, 16'hA5C3);
    txn(0, 0, 12'h07F, 16'h0000, 0, lat, rd, perr);
    chk("unqual_unchanged", rd, 16'hA5C3);

    // boundary addresses and a location for the abort test
    txn(1, 1, 12'h000, 16'h0F0F, 0, lat, rd, perr);
    txn(1, 1, 12'hFFF, 16'hF00F, 0, lat, rd, perr);
    txn(1, 1, 12'h010, 16'h1111, 0, lat, rd, perr);
    chk("wr_holds_rdata", rd, 16'hA5C3);

    // i_ce held high across 10 edges: accepts at edges 0 and 5 only
    acks = 0;
    ce = 1; we = 0; sel_we = 0; addr = 12'h000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      acks += int'(ack);
      addr  = (i % 2 == 1) ? 12'h000 : 12'hFFF;
      wdata = 16'($urandom_range(0, 16'hFFFF));
      we    = 1'($urandom_range(0, 1));
    end
    ce = 0; we = 0;
    chk("held_ce_acks", acks, 2);
    chk("held_ce_last_data", rdata, 16'hF00F);
    @(negedge clk);
    @(negedge clk);

    // reset during the write ACCESS cycle aborts the write
    ce = 1; we = 1; sel_we = 1; addr = 12'h010; wdata = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    ce = 0; we = 0; sel_we = 0;
    rst_n = 0;
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ack);
    end
    rst_n = 1;
    @(negedge clk);
    acks += int'(ack);
    chk("abort_no_ack", acks, 0);
    txn(0, 0, 12'h010, 16'h0000, 0, lat, rd, perr);
    chk("abort_old_data", rd, 16'h1111);

    // read of a just-written address
    txn(1, 1, 12'h123, 16'hBEEF, 0, lat, rd, perr);
    txn(0, 0, 12'h123, 16'h0000, 0, lat, rd, perr);
    chk("raw_data", rd, 16'hBEEF);

    // parity inject (only reported when parity is built in)
    txn(1, 1, 12'h200, 16'h0001, 1, lat, rd, perr);
    txn(0, 0, 12'h200, 16'h0000, 0, lat, rd, perr);
    chk("par_flip_data", rd, 16'h0001);
    chk("par_flip_err", perr, PAR ? 1 : 0);
    txn(1, 1, 12'h200, 16'h0001, 0, lat, rd, perr);
    txn(0, 0, 12'h200, 16'h0000, 0, lat, rd, perr);
    chk("par_clean_err", perr, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
